wash_panel_display: RTL and testbench

//  Front-panel readout for the wash controller: consumes its timer (BCD), cycle count, status and warning.

---
 rtl/wash_panel_display.sv | 177 +++++++++++++++++
 tb/tb_wash_panel_display.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wash_panel_display.sv
// wash_panel_display
//   Front-panel readout for the wash controller. Time-multiplexes a 4-digit
//   active-low seven-segment display. Each digit slot opens with a short guard
//   interval in which all anodes are off, which prevents ghosting between digits.
//   The inputs are captured once per scan frame, so a digit never shows a mix
//   of old and new values. The whole display blinks while the captured warning
//   is set.
//
//   Digit layout, with an[0] the rightmost digit:
//     d0 = timer ones, d1 = timer tens, d2 = cycle count in hex, d3 = status glyph.
//
// Ports
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous, active-low reset
//   timer_bcd  in   8  [7:4] tens, [3:0] ones, BCD
//   number     in   4  remaining cycle count, shown as hex
//   status     in   3  4=wash, 2=drain, 1=rinse, anything else shows '-'
//   warning    in   1  level; 1 requests blinking
//   blank      in   1  1 forces all anodes off from the next clk
//   an         out  4  digit enables, active-low
//   seg        out  8  segments, active-low; [0]=a..[6]=g, [7]=dp
//   frame      out  1  strobe, no handshake: high for exactly one clk in the
//                      cycle after a new snapshot has been latched
module wash_panel_display #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16,
    parameter int BLINK_FR = 250,
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] timer_bcd,
    input  logic [3:0] number,
    input  logic [2:0] status,
    input  logic       warning,
    input  logic       blank,
    output logic [3:0] an,
    output logic [7:0] seg,
    output logic       frame
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_V  = DIV_W'(GUARD);
    localparam logic [9:0]       FC_LAST  = 10'(BLINK_FR - 1);

    localparam logic [7:0] GLYPH_DASH  = 8'hBF;
    localparam logic [7:0] GLYPH_DARK  = 8'hFF;

    function automatic logic [7:0] hex_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // Prescaler and digit index
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       d_q, d_d;
    // Snapshot of the inputs, refreshed once per frame
    logic [7:0]       tim_q, tim_d;
    logic [3:0]       num_q, num_d;
    logic [2:0]       sts_q, sts_d;
    logic             warn_q, warn_d;
    // Blink state
    logic [9:0]       fc_q, fc_d;
    logic             phase_q, phase_d;
    // Registered outputs
    logic [3:0]       an_q, an_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_q, frame_d;

    logic             slot_end;
    logic             wrap;
    logic [3:0]       ones;
    logic [3:0]       tens;

    always_comb begin
        slot_end = (div_q == DIV_LAST);
        wrap     = slot_end && (d_q == 2'd3);

        div_d   = slot_end ? '0 : div_q + 1'b1;
        d_d     = slot_end ? d_q + 2'd1 : d_q;

        tim_d   = tim_q;
        num_d   = num_q;
        sts_d   = sts_q;
        warn_d  = warn_q;
        fc_d    = fc_q;
        phase_d = phase_q;
        frame_d = wrap;

        if (wrap) begin
            tim_d  = timer_bcd;
            num_d  = number;
            sts_d  = status;
            warn_d = warning;
            // A frame without warning restarts the blink, so the display is
            // always lit immediately once the warning clears.
            if (!warning) begin
                fc_d    = '0;
                phase_d = 1'b0;
            end else if (fc_q == FC_LAST) begin
                fc_d    = '0;
                phase_d = ~phase_q;
            end else begin
                fc_d    = fc_q + 10'd1;
            end
        end

        // The glyph is selected from the current digit even during the guard
        // interval, so only the anodes change at slot boundaries.
        ones = tim_q[3:0];
        tens = tim_q[7:4];
        case (d_q)
            2'd0: seg_d = (ones > 4'd9) ? GLYPH_DASH : hex_glyph(ones);
            2'd1: begin
                if (tens > 4'd9)
                    seg_d = GLYPH_DASH;
                else if (LZ_BLANK && (tens == 4'd0))
                    seg_d = GLYPH_DARK;
                else
                    seg_d = hex_glyph(tens);
            end
            2'd2: seg_d = hex_glyph(num_q);
            default: begin
                case (sts_q)
                    3'd4:    seg_d = 8'hC1;   // 'U' wash
                    3'd2:    seg_d = 8'hA1;   // 'd' drain
                    3'd1:    seg_d = 8'hAF;   // 'r' rinse
                    default: seg_d = GLYPH_DASH;
                endcase
            end
        endcase

        an_d = 4'hF;
        if ((div_q >= GUARD_V) && !blank && !(warn_q && phase_q))
            an_d[d_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            d_q     <= '0;
            tim_q   <= '0;
            num_q   <= '0;
            sts_q   <= '0;
            warn_q  <= 1'b0;
            fc_q    <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            d_q     <= d_d;
            tim_q   <= tim_d;
            num_q   <= num_d;
            sts_q   <= sts_d;
            warn_q  <= warn_d;
            fc_q    <= fc_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_wash_panel_display.sv
`timescale 1ns/1ps
module tb_wash_panel_display;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam bit LZ = 1'b1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] timer_bcd = 8'h00;
    logic [3:0] number = 4'h0;
    logic [2:0] status = 3'd0;
    logic       warning = 1'b0;
    logic       blank = 1'b0;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame;

    always #5 clk = ~clk;

    wash_panel_display #(
        .SCAN_DIV(SD),
        .GUARD(GD),
        .BLINK_FR(BF),
        .LZ_BLANK(LZ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .timer_bcd(timer_bcd),
        .number(number),
        .status(status),
        .warning(warning),
        .blank(blank),
        .an(an),
        .seg(seg),
        .frame(frame)
    );

    // ---------------- scoreboard state ----------------
    logic [12:0] exp_q[$];   // {frame, an, seg}
    int checks = 0;
    int errors = 0;

    logic [7:0] hex_tab [16];
    initial hex_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // ---------------- reference model ----------------
    // Counts clk edges since reset release; slot/digit/frame positions follow
    // by division. Blink phase is derived from how many consecutive warning
    // frames have been captured.
    int         n;
    logic [7:0] s_tim;
    logic [3:0] s_num;
    logic [2:0] s_sts;
    logic       s_warn;
    int         warn_run;

    function automatic logic [7:0] exp_glyph(input int dig, input logic [7:0] tim,
                                              input logic [3:0] num, input logic [2:0] sts);
        logic [3:0] o;
        logic [3:0] t;
        o = tim[3:0];
        t = tim[7:4];
        if (dig == 0) return (o > 9) ? 8'hBF : hex_tab[o];
        if (dig == 1) begin
            if (t > 9) return 8'hBF;
            if (LZ && t == 0) return 8'hFF;
            return hex_tab[t];
        end
        if (dig == 2) return hex_tab[num];
        if (sts == 3'd4) return 8'hC1;
        if (sts == 3'd2) return 8'hA1;
        if (sts == 3'd1) return 8'hAF;
        return 8'hBF;
    endfunction

    always @(posedge clk) begin : model
        int         pos;
        int         dig;
        bit         dark;
        logic [3:0] e_an;
        logic [7:0] e_seg;
        logic       e_frame;
        if (!rst_n) begin
            n        = 0;
            s_tim    = 8'h00;
            s_num    = 4'h0;
            s_sts    = 3'd0;
            s_warn   = 1'b0;
            warn_run = 0;
            exp_q.push_back({1'b0, 4'hF, 8'hFF});
        end else begin
            pos   = n % SD;
            dig   = (n / SD) % 4;
            e_seg = exp_glyph(dig, s_tim, s_num, s_sts);
            dark  = (pos < GD) || blank || (s_warn && (((warn_run / BF) % 2) == 1));
            e_an  = dark ? 4'hF : ~(4'b0001 << dig);
            n++;
            e_frame = 1'b0;
            if (n % (4 * SD) == 0) begin
                s_tim    = timer_bcd;
                s_num    = number;
                s_sts    = status;
                s_warn   = warning;
                warn_run = warning ? warn_run + 1 : 0;
                e_frame  = 1'b1;
            end
            exp_q.push_back({e_frame, e_an, e_seg});
        end
    end

    // ---------------- monitor ----------------
    always begin
        logic [12:0] e;
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t got frame=%0b an=%h seg=%h", $time, frame, an, seg);
        end else begin
            e = exp_q.pop_front();
            if ({frame, an, seg} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got frame=%0b an=%h seg=%h expected frame=%0b an=%h seg=%h",
                         $time, frame, an, seg, e[12], e[11:8], e[7:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic set_in(input logic [7:0] t, input logic [3:0] nm, input logic [2:0] st,
                          input logic w, input logic b);
        @(negedge clk);
        timer_bcd = t;
        number    = nm;
        status    = st;
        warning   = w;
        blank     = b;
    endtask

    // Asserts reset between edges and checks the outputs clear without a clk edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF || frame !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got an=%h seg=%h frame=%0b expected an=f seg=ff frame=0",
                     an, seg, frame);
        end
        run(3);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int cnt;
        // Reset held for 5 clocks with the digit-test values already applied.
        timer_bcd = 8'h56;
        number    = 4'hA;
        status    = 3'd4;
        warning   = 1'b0;
        blank     = 1'b0;
        run(5);
        rst_n = 1'b1;

        // First frame pulse must come on clk 32 after release.
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (frame === 1'b1) break;
        end
        checks++;
        if (cnt != 32) begin
            errors++;
            $display("FAIL first_frame got clk=%0d expected clk=32", cnt);
        end

        run(70);                                         // digits 5/6/A/U
        set_in(8'h05, 4'hA, 3'd4, 1'b0, 1'b0); run(70);  // leading-zero blank
        set_in(8'h3C, 4'hA, 3'd4, 1'b0, 1'b0); run(70);  // non-BCD ones
        set_in(8'h3C, 4'hA, 3'd3, 1'b0, 1'b0); run(70);  // unknown status
        set_in(8'h12, 4'h2, 3'd2, 1'b0, 1'b0); run(45);  // tearing: 2 ...
        set_in(8'h12, 4'h7, 3'd1, 1'b0, 1'b0); run(70);  // ... then 7 mid-frame
        set_in(8'h99, 4'hF, 3'd4, 1'b1, 1'b0); run(300); // warning blink
        set_in(8'h99, 4'hF, 3'd4, 1'b0, 1'b0); run(70);  // warning cleared
        run(13);
        set_in(8'h47, 4'h3, 3'd4, 1'b0, 1'b1); run(6);   // blank mid-slot
        set_in(8'h47, 4'h3, 3'd4, 1'b0, 1'b0); run(7);
        async_reset();
        run(40);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            set_in({4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))},
                   4'($urandom_range(0, 15)),
                   3'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 5) == 0));
            run($urandom_range(1, 50));
            if ($urandom_range(0, 19) == 0) async_reset();
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
